// File: rtl/mic_pkg.sv
// mic_pkg: shared constants and types for the I2S MEMS microphone receiver.
//   SLOT_BITS / FRAME_BITS : SCK periods per slot / per stereo frame
//   FC_BITS / SLOT_IDX_W   : widths of the frame counter and of the in-slot index
//   DEFAULT_CLK_DIV        : system-clock cycles per SCK half-period
//   DEFAULT_DATA_BITS      : significant bits captured per slot
//   sample_t               : signed sample at the default width
package mic_pkg;

  localparam int SLOT_BITS         = 32;
  localparam int FRAME_BITS        = 64;
  localparam int FC_BITS           = $clog2(FRAME_BITS);
  localparam int SLOT_IDX_W        = $clog2(SLOT_BITS);
  localparam int DEFAULT_CLK_DIV   = 16;
  localparam int DEFAULT_DATA_BITS = 24;

  typedef logic signed [DEFAULT_DATA_BITS-1:0] sample_t;

endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: I2S bit clock / word select generator.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   sck_o   I2S bit clock, toggles every CLK_DIV system cycles
//   ws_o    word select (0 = left slot, 1 = right slot), changes only with SCK falling
//   rise_o  high in the system cycle at whose end SCK goes 0->1
//   fall_o  high in the system cycle at whose end SCK goes 1->0
//   fc_o    frame counter (SCK periods into the 64-period frame), pre-increment value
module i2s_clkgen
  import mic_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               sck_o,
  output logic               ws_o,
  output logic               rise_o,
  output logic               fall_o,
  output logic [FC_BITS-1:0] fc_o
);

  // CLK_DIV = 1 still needs a one-bit counter that simply wraps every cycle.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               sck_q, sck_d;
  logic [FC_BITS-1:0] fc_q, fc_d;
  logic               wrap;

  always_comb begin
    wrap      = (div_cnt_q == DIV_LAST);
    div_cnt_d = wrap ? '0 : div_cnt_q + DIV_W'(1);
    sck_d     = wrap ? ~sck_q : sck_q;
    rise_o    = wrap & ~sck_q;
    fall_o    = wrap & sck_q;
    // Frame position advances on SCK falling edges, modulo 64.
    fc_d      = fall_o ? fc_q + FC_BITS'(1) : fc_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
      fc_q      <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
      fc_q      <= fc_d;
    end
  end

  assign sck_o = sck_q;
  // fc_q is itself a register, so WS moves on the same edge SCK falls.
  assign ws_o  = fc_q[FC_BITS-1];
  assign fc_o  = fc_q;

endmodule

// File: rtl/microphones.sv
// microphones: I2S receiver for INMP441-class MEMS microphones.
// Generates SCK/WS from the system clock and deserialises MSB-first
// two's-complement words into signed parallel samples.
//   clk_in       system clock (100 MHz)
//   rst_in       asynchronous active-low reset
//   mic_data     serial data from the microphone(s)
//   mic_sck      I2S bit clock
//   mic_ws       word select: 0 = left slot, 1 = right slot
//   left_out     signed left sample, held until the next left word
//   right_out    signed right sample, held until the next right word
//   left_valid   one-cycle strobe when left_out updates
//   right_valid  one-cycle strobe when right_out updates
// Build option: define MIC_STEREO_EN to capture the right slot as well;
// without it only the left slot is captured and right_out/right_valid stay 0.
//
// Valid protocol: left_valid/right_valid are single-cycle strobes with no
// back-pressure. The matching sample output changes in the strobe cycle and
// is then stable until the next strobe of the same slot; the two strobes are
// never high together.
module microphones
  import mic_pkg::*;
#(
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        mic_data,
  output logic                        mic_sck,
  output logic                        mic_ws,
  output logic signed [DATA_BITS-1:0] left_out,
  output logic signed [DATA_BITS-1:0] right_out,
  output logic                        left_valid,
  output logic                        right_valid
);

  localparam logic [SLOT_IDX_W-1:0] LAST_BIT = SLOT_IDX_W'(DATA_BITS);

  logic                  sck_rise, sck_fall;
  logic [FC_BITS-1:0]    fc;
  logic [SLOT_IDX_W-1:0] bit_pos;

  logic [DATA_BITS-1:0]  sr_q, sr_d;
  logic [DATA_BITS:0]    sr_ext;
  logic                  done_q, done_d;
  logic                  done_slot_q, done_slot_d;
  logic [DATA_BITS-1:0]  left_q, left_d;
  logic [DATA_BITS-1:0]  right_q, right_d;
  logic                  left_valid_q, left_valid_d;
  logic                  right_valid_q, right_valid_d;

  i2s_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .sck_o  (mic_sck),
    .ws_o   (mic_ws),
    .rise_o (sck_rise),
    .fall_o (sck_fall),
    .fc_o   (fc)
  );

  always_comb begin
    bit_pos       = fc[SLOT_IDX_W-1:0];
    sr_ext        = {sr_q, mic_data};
    sr_d          = sr_q;
    done_d        = 1'b0;
    done_slot_d   = done_slot_q;
    left_d        = left_q;
    right_d       = right_q;
    left_valid_d  = 1'b0;
    right_valid_d = 1'b0;

    // Position 0 is the I2S delay bit; positions 1..DATA_BITS carry the word
    // MSB first; the rest of the slot is padding.
    if (sck_fall && (bit_pos != '0) && (bit_pos <= LAST_BIT)) begin
      sr_d = sr_ext[DATA_BITS-1:0];
    end else if (sck_rise && (bit_pos == '0)) begin
      // Start every slot from a clean shifter.
      sr_d = '0;
    end

    // LSB captured: remember which slot it belonged to and publish next cycle.
    if (sck_fall && (bit_pos == LAST_BIT)) begin
      done_d      = 1'b1;
      done_slot_d = fc[FC_BITS-1];
    end

    if (done_q && !done_slot_q) begin
      left_d       = sr_q;
      left_valid_d = 1'b1;
    end
`ifdef MIC_STEREO_EN
    if (done_q && done_slot_q) begin
      right_d       = sr_q;
      right_valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sr_q          <= '0;
      done_q        <= 1'b0;
      done_slot_q   <= 1'b0;
      left_q        <= '0;
      right_q       <= '0;
      left_valid_q  <= 1'b0;
      right_valid_q <= 1'b0;
    end else begin
      sr_q          <= sr_d;
      done_q        <= done_d;
      done_slot_q   <= done_slot_d;
      left_q        <= left_d;
      right_q       <= right_d;
      left_valid_q  <= left_valid_d;
      right_valid_q <= right_valid_d;
    end
  end

  assign left_out    = left_q;
  assign right_out   = right_q;
  assign left_valid  = left_valid_q;
  assign right_valid = right_valid_q;

endmodule

// File: tb/tb_microphones.sv
// tb_microphones: directed bench for the microphones I2S receiver.
// A microphone model drives mic_data on SCK rises from per-slot word queues
// and pushes each word it starts into the expected queue of its slot; every
// valid strobe pops and compares.
`timescale 1ns/1ps
module tb_microphones;
  import mic_pkg::*;

  localparam int DB  = DEFAULT_DATA_BITS;
  localparam int DIV = DEFAULT_CLK_DIV;

  // ---------------- clock / reset ----------------
  logic clk_in   = 1'b0;
  logic rst_in   = 1'b0;
  logic mic_data = 1'b0;
  logic mic_sck, mic_ws;
  logic signed [DB-1:0] left_out, right_out;
  logic left_valid, right_valid;

  always #5 clk_in = ~clk_in;

  microphones #(.CLK_DIV(DIV), .DATA_BITS(DB)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .mic_data    (mic_data),
    .mic_sck     (mic_sck),
    .mic_ws      (mic_ws),
    .left_out    (left_out),
    .right_out   (right_out),
    .left_valid  (left_valid),
    .right_valid (right_valid)
  );

  // ---------------- scoreboard state ----------------
  logic [DB-1:0] word_left_q[$];
  logic [DB-1:0] word_right_q[$];
  logic [DB-1:0] exp_left_q[$];
  logic [DB-1:0] exp_right_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int fall_cnt = 0;
  int cyc      = 0;
  int cap_cyc  = -100;
  int cap_slot = 0;
  int lv_cnt   = 0;
  int rv_cnt   = 0;
  logic prev_sck = 1'b0;
  logic [DB-1:0] cur_word = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // ---------------- microphone model + strobe monitor ----------------
  initial begin : mic_model
    int pos;
    int p;
    logic [DB-1:0] got;
    forever begin
      @(negedge clk_in);
      cyc++;
      if (left_valid)  lv_cnt++;
      if (right_valid) rv_cnt++;
      if (rst_in !== 1'b1) begin
        fall_cnt = 0;
        prev_sck = 1'b0;
        mic_data = 1'b0;
        cur_word = '0;
        cap_cyc  = -100;
        word_left_q.delete();
        word_right_q.delete();
        exp_left_q.delete();
        exp_right_q.delete();
      end else begin
        pos = fall_cnt % 64;
        p   = pos % 32;
        if (mic_sck && !prev_sck) begin
          // Data changes on SCK rise, ahead of the fall that samples position pos.
          if (p == 1) begin
            if (pos >= 32) begin
              cur_word = (word_right_q.size() != 0) ? word_right_q.pop_front() : '0;
`ifdef MIC_STEREO_EN
              exp_right_q.push_back(cur_word);
`endif
            end else begin
              cur_word = (word_left_q.size() != 0) ? word_left_q.pop_front() : '0;
              exp_left_q.push_back(cur_word);
            end
          end
          mic_data = (p >= 1 && p <= DB) ? cur_word[DB-p] : 1'b0;
        end
        if (!mic_sck && prev_sck) begin
          if (p == DB) begin
            cap_cyc  = cyc;
            cap_slot = (pos >= 32) ? 1 : 0;
          end
          fall_cnt++;
        end
        prev_sck = mic_sck;

        if (left_valid || right_valid) begin
          check_eq("strobe_both", 32'(left_valid & right_valid), 32'd0);
          check_eq("strobe_latency", 32'(cyc - cap_cyc), 32'd1);
          check_eq("strobe_slot", 32'(right_valid), 32'(cap_slot));
          if (left_valid) begin
            got = left_out;
            if (exp_left_q.size() == 0) check_eq("left_unexpected", 32'd1, 32'd0);
            else check_eq("left_word", 32'(got), 32'(exp_left_q.pop_front()));
          end
          if (right_valid) begin
            got = right_out;
            if (exp_right_q.size() == 0) check_eq("right_unexpected", 32'd1, 32'd0);
            else check_eq("right_word", 32'(got), 32'(exp_right_q.pop_front()));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Wait until the model has seen 63 falls of a frame: the next rise after
  // the upcoming fall begins a fresh left slot.
  task automatic align_frame();
    int n = 0;
    while ((fall_cnt % 64) != 63 && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    check_eq("align_timeout", 32'(n >= 3000), 32'd0);
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((word_left_q.size() + word_right_q.size() + exp_left_q.size() + exp_right_q.size()) != 0
           && n < max_cyc) begin
      @(negedge clk_in);
      n++;
    end
    check_eq("drain_timeout", 32'(n >= max_cyc), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main_seq
    int r1, r2, wr, wf, wr2, base, n, l0, r0;
    logic prev, pws;
    logic [DB-1:0] w;
    logic [31:0] su;
    int s;
    real a;

    // Reset state
    rst_in = 1'b0;
    repeat (20) @(negedge clk_in);
    check_eq("rst_sck", 32'(mic_sck), 32'd0);
    check_eq("rst_ws", 32'(mic_ws), 32'd0);
    check_eq("rst_left", 32'(left_out), 32'd0);
    check_eq("rst_right", 32'(right_out), 32'd0);
    check_eq("rst_lvalid", 32'(left_valid), 32'd0);
    check_eq("rst_rvalid", 32'(right_valid), 32'd0);

    // Clock generation: SCK high after 16 cycles, period 32 cycles (320 ns);
    // WS rises at the 32nd fall = 32 * 2 * 16 = 1024 cycles, 50 % duty over 64 SCK.
    @(negedge clk_in);
    rst_in = 1'b1;
    r1 = -1; r2 = -1; wr = -1; wf = -1; wr2 = -1;
    prev = 1'b0; pws = 1'b0;
    for (int k = 1; k <= 3200 && wr2 < 0; k++) begin
      @(posedge clk_in);
      #1;
      if (mic_sck && !prev) begin
        if (r1 < 0) r1 = k;
        else if (r2 < 0) r2 = k;
      end
      if (mic_ws != pws) begin
        check_eq("ws_on_sck_fall", 32'({prev, mic_sck}), 32'd2);
        if (mic_ws) begin
          if (wr < 0) wr = k;
          else wr2 = k;
        end else begin
          wf = k;
        end
      end
      prev = mic_sck;
      pws  = mic_ws;
    end
    check_eq("first_sck_rise", 32'(r1), 32'd16);
    check_eq("sck_period", 32'(r2 - r1), 32'd32);
    check_eq("ws_first_rise", 32'(wr), 32'd1024);
    check_eq("ws_high_time", 32'(wf - wr), 32'd1024);
    check_eq("ws_period", 32'(wr2 - wr), 32'd2048);

    // Left and right words in one frame; left must hold through the right update.
    align_frame();
    word_left_q.push_back(24'h7FFFFF);
    word_right_q.push_back(24'h800001);
    drain(5000);
    w = left_out;
    check_eq("left_held", 32'(w), 32'h7FFFFF);
    w = right_out;
`ifdef MIC_STEREO_EN
    check_eq("right_final", 32'(w), 32'h800001);
`else
    check_eq("right_final", 32'(w), 32'h0);
`endif

    // Sine sweep: top 24 bits of 0x7FFFFFFF*sin(64*i deg), alternating slots.
    align_frame();
    for (int i = 0; i < 30; i++) begin
      a  = 64.0 * i * 2.0 * 3.14159265358979 / 360.0;
      s  = int'(2147483647.0 * $sin(a));
      su = s;
      w  = su[31:8];
      if ((i % 2) == 0) word_left_q.push_back(w);
      else word_right_q.push_back(w);
    end
    drain(40000);

    // Reset after 10 bits of a left word.
    align_frame();
    base = fall_cnt;
    word_left_q.push_back(24'h5A5A5A);
    word_left_q.push_back(24'h123456);
    n = 0;
    while (fall_cnt < base + 1 + 64 + 11 && n < 6000) begin
      @(negedge clk_in);
      n++;
    end
    check_eq("midword_timeout", 32'(n >= 6000), 32'd0);
    w = left_out;
    check_eq("pre_reset_left", 32'(w), 32'h5A5A5A);
    @(negedge clk_in);
    rst_in = 1'b0;
    l0 = lv_cnt;
    r0 = rv_cnt;
    repeat (5) @(negedge clk_in);
    check_eq("midrst_left", 32'(left_out), 32'd0);
    check_eq("midrst_right", 32'(right_out), 32'd0);
    check_eq("midrst_ws", 32'(mic_ws), 32'd0);
    check_eq("midrst_lstrobes", 32'(lv_cnt - l0), 32'd0);
    check_eq("midrst_rstrobes", 32'(rv_cnt - r0), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    align_frame();
    word_left_q.push_back(24'hABCDEF);
    word_right_q.push_back(24'h00F00D);
    drain(5000);
    w = left_out;
    check_eq("post_reset_left", 32'(w), 32'hABCDEF);

`ifdef MIC_STEREO_EN
    check_eq("right_strobes_seen", 32'(rv_cnt > 0), 32'd1);
`else
    check_eq("right_strobes_seen", 32'(rv_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
